// File: rtl/result_uart_reporter.sv
// Reports a 64-bit solver result as decimal ASCII over a UART 8N1 line,
// followed by CR LF, once per rising level of done.
//
// state   | meaning
// IDLE    | waiting for done; tx idle high
// CONVERT | 64 double-dabble shifts of the latched count into 20 BCD digits
// SKIP    | drop leading zero digits, one per cycle, keeping the last digit
// SEND    | serialise the remaining digits, then CR, then LF, back-to-back
// HOLD    | report complete (sent=1); wait for done to drop before re-arming
module result_uart_reporter #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] count,
  input  logic        done,
  output logic        tx,
  output logic        busy,
  output logic        sent
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CONVERT = 3'd1;
  localparam logic [2:0] S_SKIP    = 3'd2;
  localparam logic [2:0] S_SEND    = 3'd3;
  localparam logic [2:0] S_HOLD    = 3'd4;

  localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic [4:0]  TOP_DIGIT   = 5'd19;

  localparam logic [1:0] TAIL_DIGITS = 2'd0;
  localparam logic [1:0] TAIL_CR     = 2'd1;
  localparam logic [1:0] TAIL_LF     = 2'd2;

  logic [2:0]  state_q, state_d;
  logic [63:0] shadow_q, shadow_d;
  logic [79:0] bcd_q, bcd_d;
  logic [5:0]  shift_cnt_q, shift_cnt_d;
  logic [4:0]  dig_q, dig_d;
  logic [1:0]  tail_q, tail_d;
  logic [9:0]  frame_q, frame_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] baud_q, baud_d;
  logic        busy_q, busy_d;
  logic        sent_q, sent_d;

  logic [79:0] bcd_adj;
  logic [3:0]  cur_digit;
  logic [3:0]  nxt_digit;
  logic [4:0]  dig_m1;

  function automatic logic [9:0] frame_of(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  // Double-dabble correction: any digit >= 5 gets +3 before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 20; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) begin
        bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
      end
    end
  end

  assign dig_m1    = dig_q - 5'd1;
  assign cur_digit = bcd_q[{dig_q, 2'b00} +: 4];
  assign nxt_digit = bcd_q[{dig_m1, 2'b00} +: 4];

  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    bcd_d       = bcd_q;
    shift_cnt_d = shift_cnt_q;
    dig_d       = dig_q;
    tail_d      = tail_q;
    frame_d     = frame_q;
    bit_d       = bit_q;
    baud_d      = baud_q;
    busy_d      = busy_q;
    sent_d      = sent_q;

    case (state_q)
      S_IDLE: begin
        if (done) begin
          shadow_d    = count;
          bcd_d       = '0;
          shift_cnt_d = 6'd63;
          busy_d      = 1'b1;
          state_d     = S_CONVERT;
        end
      end

      S_CONVERT: begin
        bcd_d    = {bcd_adj[78:0], shadow_q[63]};
        shadow_d = {shadow_q[62:0], 1'b0};
        if (shift_cnt_q == 6'd0) begin
          dig_d   = TOP_DIGIT;
          state_d = S_SKIP;
        end else begin
          shift_cnt_d = shift_cnt_q - 6'd1;
        end
      end

      S_SKIP: begin
        if (cur_digit == 4'd0 && dig_q != 5'd0) begin
          dig_d = dig_m1;
        end else begin
          tail_d  = TAIL_DIGITS;
          frame_d = frame_of({4'h3, cur_digit});
          bit_d   = 4'd0;
          baud_d  = BAUD_RELOAD;
          state_d = S_SEND;
        end
      end

      S_SEND: begin
        if (baud_q != 16'd0) begin
          baud_d = baud_q - 16'd1;
        end else if (bit_q != 4'd9) begin
          frame_d = {1'b1, frame_q[9:1]};
          bit_d   = bit_q + 4'd1;
          baud_d  = BAUD_RELOAD;
        end else begin
          // Stop bit done: the next frame's start bit begins on this edge.
          bit_d  = 4'd0;
          baud_d = BAUD_RELOAD;
          case (tail_q)
            TAIL_DIGITS: begin
              if (dig_q == 5'd0) begin
                tail_d  = TAIL_CR;
                frame_d = frame_of(8'h0D);
              end else begin
                dig_d   = dig_m1;
                frame_d = frame_of({4'h3, nxt_digit});
              end
            end
            TAIL_CR: begin
              tail_d  = TAIL_LF;
              frame_d = frame_of(8'h0A);
            end
            default: begin
              busy_d  = 1'b0;
              sent_d  = 1'b1;
              state_d = S_HOLD;
            end
          endcase
        end
      end

      S_HOLD: begin
        if (!done) begin
          sent_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      shadow_q    <= '0;
      bcd_q       <= '0;
      shift_cnt_q <= '0;
      dig_q       <= '0;
      tail_q      <= TAIL_DIGITS;
      frame_q     <= '1;
      bit_q       <= '0;
      baud_q      <= '0;
      busy_q      <= 1'b0;
      sent_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      bcd_q       <= bcd_d;
      shift_cnt_q <= shift_cnt_d;
      dig_q       <= dig_d;
      tail_q      <= tail_d;
      frame_q     <= frame_d;
      bit_q       <= bit_d;
      baud_q      <= baud_d;
      busy_q      <= busy_d;
      sent_q      <= sent_d;
    end
  end

  assign tx   = (state_q == S_SEND) ? frame_q[0] : 1'b1;
  assign busy = busy_q;
  assign sent = sent_q;

endmodule

// File: doc/result_uart_reporter.md
RESULT_UART_REPORTER -- requirements
Module: result_uart_reporter

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per UART bit; legal range 2..65535.
REQ-002 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-004 SHALL have port count, input, 64, unsigned puzzle result from the solver.
REQ-005 SHALL have port done, input, 1, level-high when count is final.
REQ-006 SHALL have port tx, output, 1, UART 8N1 serial line, idle high.
REQ-007 SHALL have port busy, output, 1, high from trigger until the last stop bit completes.
REQ-008 SHALL have port sent, output, 1, high after a complete report until done deasserts.

Function
REQ-009 SHALL use states IDLE, CONVERT, SKIP, SEND, HOLD.
REQ-010 SHALL transition IDLE->CONVERT on the first clk edge where done=1; count is latched into a 64-bit shadow register on that edge, and busy=1 from the next cycle.
REQ-011 SHALL ignore count changes after the latch; the report reflects the latched value only.
REQ-012 SHALL convert binary to 20 BCD digits by double-dabble, one shift per cycle, exactly 64 cycles in CONVERT.
REQ-013 SHALL in SKIP drop leading zero digits, one per cycle, max 19; the least significant digit is always sent, so count=0 yields "0".
REQ-014 SHALL in SEND transmit remaining digits most-significant first as ASCII 0x30+digit, then 0x0D, then 0x0A.
REQ-015 SHALL frame each byte as start bit 0, 8 data bits LSB first, stop bit 1, each bit exactly CLKS_PER_BIT cycles.
REQ-016 SHALL send frames back-to-back: start bit of frame N+1 begins the cycle after stop bit of frame N ends; no idle gap.
REQ-017 SHALL hold tx=1 in every state except during SEND frame bits.
REQ-018 SHALL on completion of the 0x0A stop bit enter HOLD, drive busy=0 and sent=1 on the same edge.
REQ-019 SHALL remain in HOLD while done=1 (no retrigger); when done=0 go to IDLE and clear sent on that edge.
REQ-020 SHALL ignore done deassertion during CONVERT, SKIP or SEND; the report runs to completion.
REQ-021 SHALL total report length be (digits+2) frames of 10*CLKS_PER_BIT cycles each.

Reset
REQ-022 SHALL on any clk edge with rst=0 force state IDLE, tx=1, busy=0, sent=0, clear shadow, BCD and bit counters, regardless of current state.
REQ-023 SHALL abort an in-flight frame on reset; tx=1 from the cycle following the reset edge.
REQ-024 SHALL, if done=1 on the first edge after rst returns high, start a new report per REQ-010.

Verification
REQ-025 SHALL cover: CLKS_PER_BIT=4, count=1234, done raised -> 6 frames 0x31 0x32 0x33 0x34 0x0D 0x0A, each 40 cycles, no gaps, then sent=1 busy=0.
REQ-026 SHALL cover: count=0 -> exactly 3 frames 0x30 0x0D 0x0A.
REQ-027 SHALL cover: count=0xFFFFFFFFFFFFFFFF -> 22 frames "18446744073709551615\r\n".
REQ-028 SHALL cover: count=7, done held high 2 report lengths -> one report only; done low 1 cycle then high -> second identical report, sent cleared in between.
REQ-029 SHALL cover: count=1234, rst=0 asserted mid data bit of second frame -> tx=1, busy=0, sent=0 next cycle; no further frames while done=0.
REQ-030 SHALL cover: count changed to 99 one cycle after done rises -> report still "1234\r\n".
